// File: rtl/udp_rx_pkt_buffer.sv
// UDP receive packet buffer: beat RAM plus descriptor FIFO, commit-or-drop per packet.
// Define UDP_RX_BUF_ERR_DROP_EN to drop packets flagged by s_terr_i on their tlast beat.
module udp_rx_pkt_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int PKT_W  = 6,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              resetn,
    input  logic              s_tvalid_i,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tlast_i,
    input  logic              s_terr_i,
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tlast_o,
    output logic [LEN_W-1:0]  m_tsize_o,
    output logic [PKT_W:0]    cached_pkt_num_o,
    output logic [15:0]       drop_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NDESC = 1 << PKT_W;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [PKT_W:0]   PKT_MAX = {1'b1, {PKT_W{1'b0}}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LEN_W-1:0]  r_desc [NDESC];
    logic [DATA_W-1:0] r_rdata;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_commit_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_dropping;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [PKT_W:0]    r_dwr;
    logic [PKT_W:0]    r_drd;
    logic [PKT_W:0]    r_cached;
    logic [15:0]       r_drop_cnt;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_tsize;
    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] w_wr_ptr_inc;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_desc_head;
    logic              w_full;
    logic              w_len_ovf;
    logic              w_desc_full;
    logic              w_desc_empty;
    logic              w_err;
    logic              w_beat_bad;
    logic              w_wr_en;
    logic              w_eop;
    logic              w_commit;
    logic              w_drop;
    logic              w_hs;
    logic              w_last_hs;
    logic              w_rd_en;

`ifdef UDP_RX_BUF_ERR_DROP_EN
    assign w_err = s_terr_i;
`else
    // error flag has no effect in this build
    assign w_err = s_terr_i & 1'b0;
`endif

    assign w_wr_ptr_inc = r_wr_ptr + 1'b1;
    assign w_len        = r_beat_cnt + 1'b1;
    assign w_full       = (w_wr_ptr_inc == r_rd_ptr);
    assign w_len_ovf    = (r_beat_cnt == LEN_MAX);
    // Capacity counts the packet being streamed, so cached never exceeds 2^PKT_W
    assign w_desc_full  = (r_cached == PKT_MAX);
    assign w_desc_empty = (r_dwr == r_drd);
    assign w_desc_head  = r_desc[r_drd[PKT_W-1:0]];

    assign w_beat_bad = r_dropping | w_full | w_len_ovf;
    assign w_wr_en    = s_tvalid_i & ~w_beat_bad;
    assign w_eop      = s_tvalid_i & s_tlast_i;
    assign w_commit   = w_eop & ~w_beat_bad & ~w_desc_full & ~w_err;
    assign w_drop     = w_eop & ~w_commit;

    assign w_hs      = (r_state == S_STREAM) & m_tready_i;
    assign w_last_hs = w_hs & (r_remaining == LEN_ONE);
    assign w_rd_en   = (r_state == S_LOAD) | w_hs;
    assign w_rd_addr = w_hs ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= s_tdata_i;
        end
        if (w_rd_en) begin
            r_rdata <= r_mem[w_rd_addr];
        end
        if (w_commit) begin
            r_desc[r_dwr[PKT_W-1:0]] <= w_len;
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_dropping   <= 1'b0;
            r_beat_cnt   <= '0;
            r_drop_cnt   <= '0;
            r_dwr        <= '0;
        end else if (w_drop) begin
            r_wr_ptr   <= r_commit_ptr;
            r_dropping <= 1'b0;
            r_beat_cnt <= '0;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (w_commit) begin
            r_wr_ptr     <= w_wr_ptr_inc;
            r_commit_ptr <= w_wr_ptr_inc;
            r_dropping   <= 1'b0;
            r_beat_cnt   <= '0;
            r_dwr        <= r_dwr + 1'b1;
        end else if (s_tvalid_i) begin
            if (w_beat_bad) begin
                r_dropping <= 1'b1;
            end else begin
                r_wr_ptr   <= w_wr_ptr_inc;
                r_beat_cnt <= w_len;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_desc_empty || w_commit) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (w_last_hs) begin
                    w_state_nxt = (!w_desc_empty || w_commit) ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_tsize     <= '0;
            r_drd       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_LOAD) begin
                r_tsize     <= w_desc_head;
                r_remaining <= w_desc_head;
                r_drd       <= r_drd + 1'b1;
            end else if (w_hs) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            r_cached <= '0;
        end else if (w_commit && !w_last_hs) begin
            r_cached <= r_cached + 1'b1;
        end else if (!w_commit && w_last_hs) begin
            r_cached <= r_cached - 1'b1;
        end
    end

    assign m_tdata_o        = r_rdata;
    assign m_tvalid_o       = (r_state == S_STREAM);
    assign m_tlast_o        = (r_state == S_STREAM) && (r_remaining == LEN_ONE);
    assign m_tsize_o        = r_tsize;
    assign cached_pkt_num_o = r_cached;
    assign drop_cnt_o       = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Scoreboard bench for udp_rx_pkt_buffer (small RAM and descriptor FIFO build).
module tb_udp_rx_pkt_buffer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int PW = 2;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          resetn = 1'b1;
    logic          s_tvalid_i = 1'b0;
    logic [DW-1:0] s_tdata_i = '0;
    logic          s_tlast_i = 1'b0;
    logic          s_terr_i = 1'b0;
    logic [DW-1:0] m_tdata_o;
    logic          m_tvalid_o;
    logic          m_tready_i = 1'b0;
    logic          m_tlast_o;
    logic [LW-1:0] m_tsize_o;
    logic [PW:0]   cached_pkt_num_o;
    logic [15:0]   drop_cnt_o;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [15:0] sz;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pkt[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         rdy_mode = 0;

    udp_rx_pkt_buffer #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .PKT_W (PW),
        .LEN_W (LW)
    ) dut (
        .clk_i           (clk_i),
        .resetn          (resetn),
        .s_tvalid_i      (s_tvalid_i),
        .s_tdata_i       (s_tdata_i),
        .s_tlast_i       (s_tlast_i),
        .s_terr_i        (s_terr_i),
        .m_tdata_o       (m_tdata_o),
        .m_tvalid_o      (m_tvalid_o),
        .m_tready_i      (m_tready_i),
        .m_tlast_o       (m_tlast_o),
        .m_tsize_o       (m_tsize_o),
        .cached_pkt_num_o(cached_pkt_num_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ready: 0 = held low, 1 = held high, 2 = toggles every cycle
    initial forever begin
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0: m_tready_i = 1'b0;
            1: m_tready_i = 1'b1;
            default: m_tready_i = ~m_tready_i;
        endcase
    end

    // Each valid output cycle is compared with the scoreboard head;
    // the head is popped only on a handshake, so stalls must hold it.
    initial forever begin
        @(negedge clk_i);
        if (resetn && m_tvalid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(m_tdata_o), 32'hFFFF_FFFF);
            end else begin
                chk(m_tready_i ? "hs_data" : "stall_data",
                    32'(m_tdata_o), 32'(sb[0].d));
                chk(m_tready_i ? "hs_last" : "stall_last",
                    32'(m_tlast_o), 32'(sb[0].l));
                chk(m_tready_i ? "hs_size" : "stall_size",
                    32'(m_tsize_o), 32'(sb[0].sz));
                if (m_tready_i) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_terr_i   = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        resetn = 1'b1;
    endtask

    task automatic fill(input int n, input logic [7:0] base,
                        input logic [7:0] step);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(base + 8'(i) * step);
    endtask

    // Called one step after a rising edge; returns one step after the tlast edge.
    task automatic send(input bit err, input bit exp_ok);
        int   n;
        exp_t e;
        n = pkt.size();
        if (exp_ok) begin
            for (int i = 0; i < n; i++) begin
                e.d  = pkt[i];
                e.l  = (i == n - 1);
                e.sz = 16'(n);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = pkt[i];
            s_tlast_i  = (i == n - 1);
            s_terr_i   = err && (i == n - 1);
            @(posedge clk_i);
            #1;
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
        s_terr_i   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk_i);
        chk(tag, 32'(sb.size()), 0);
        repeat (3) @(negedge clk_i);
        chk({tag, "_idle"}, 32'(m_tvalid_o), 0);
        chk({tag, "_cached"}, 32'(cached_pkt_num_o), 0);
    endtask

    initial begin
        bit got_valid;

        #2;
        resetn = 1'b0;
        #1;
        chk("rst_valid", 32'(m_tvalid_o), 0);
        chk("rst_last", 32'(m_tlast_o), 0);
        chk("rst_size", 32'(m_tsize_o), 0);
        chk("rst_cached", 32'(cached_pkt_num_o), 0);
        chk("rst_drop", 32'(drop_cnt_o), 0);
        do_reset();

        // 4-beat packet, ready high: LOAD then 4 consecutive beats
        rdy_mode = 1;
        sync();
        fill(4, 8'h11, 8'h11);
        send(1'b0, 1'b1);
        @(negedge clk_i);
        chk("t1_load_valid", 32'(m_tvalid_o), 0);
        chk("t1_cached_one", 32'(cached_pkt_num_o), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("t1_stream_valid", 32'(m_tvalid_o), 1);
        end
        @(negedge clk_i);
        chk("t1_end_valid", 32'(m_tvalid_o), 0);
        chk("t1_cached_zero", 32'(cached_pkt_num_o), 0);
        wait_drain("t1_drain");

        // 3, 1 and 5 beat packets back to back, ready toggling
        rdy_mode = 2;
        sync();
        fill(3, 8'h30, 8'h01);
        send(1'b0, 1'b1);
        fill(1, 8'h40, 8'h01);
        send(1'b0, 1'b1);
        fill(5, 8'h50, 8'h03);
        send(1'b0, 1'b1);
        wait_drain("t2_drain");
        chk("t2_drop", 32'(drop_cnt_o), 0);

        // RAM overflow: 10-beat packet kept, 8-beat packet dropped
        do_reset();
        rdy_mode = 0;
        sync();
        fill(10, 8'h60, 8'h01);
        send(1'b0, 1'b1);
        fill(8, 8'hA0, 8'h01);
        send(1'b0, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("t3_drop", 32'(drop_cnt_o), 1);
        chk("t3_cached", 32'(cached_pkt_num_o), 1);
        rdy_mode = 1;
        wait_drain("t3_drain");

        // descriptor capacity: four commits, fifth dropped
        do_reset();
        rdy_mode = 0;
        sync();
        for (int p = 0; p < 5; p++) begin
            fill(1, 8'(p + 1), 8'h01);
            send(1'b0, p < 4);
        end
        repeat (3) @(negedge clk_i);
        chk("t4_drop", 32'(drop_cnt_o), 1);
        chk("t4_cached", 32'(cached_pkt_num_o), 4);
        rdy_mode = 1;
        wait_drain("t4_drain");

        // errored packet
        do_reset();
        rdy_mode = 1;
        sync();
        fill(3, 8'hE0, 8'h01);
`ifdef UDP_RX_BUF_ERR_DROP_EN
        send(1'b1, 1'b0);
        repeat (2) @(negedge clk_i);
        chk("t5_drop", 32'(drop_cnt_o), 1);
`else
        send(1'b1, 1'b1);
        repeat (2) @(negedge clk_i);
        chk("t5_drop", 32'(drop_cnt_o), 0);
`endif
        wait_drain("t5_drain");

        // reset during STREAM, then a fresh 2-beat packet
        do_reset();
        rdy_mode = 0;
        sync();
        fill(3, 8'h70, 8'h01);
        send(1'b0, 1'b1);
        got_valid = 1'b0;
        for (int i = 0; i < 10 && !got_valid; i++) begin
            @(negedge clk_i);
            got_valid = m_tvalid_o;
        end
        chk("t6_reach_stream", 32'(got_valid), 1);
        chk("t6_pre_size", 32'(m_tsize_o), 3);
        resetn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_tvalid_o), 0);
        chk("t6_rst_cached", 32'(cached_pkt_num_o), 0);
        chk("t6_rst_size", 32'(m_tsize_o), 0);
        chk("t6_rst_drop", 32'(drop_cnt_o), 0);
        do_reset();
        rdy_mode = 1;
        sync();
        fill(2, 8'hA1, 8'h01);
        send(1'b0, 1'b1);
        wait_drain("t6_drain");
        chk("t6_drop", 32'(drop_cnt_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
